dac_frame_receiver: RTL and testbench

Receive-side counterpart to the SPI DAC transmitter in the music player. The block oversamples the three-wire DAC link (`sclk`, `sync`, `mosi`) in the system clock domain and reassembles each frame into a parallel word. It decodes the AD5621-style fields (power-down mode, 12-bit code) and flags malformed frames. It is used in loopback on the board and as the checker in the bench, so that the transmitter's output can be compared sample by sample against the sinusoid table.

---
 rtl/dac_frame_receiver.sv | 106 ++++++++++
 tb/tb_dac_frame_receiver.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dac_frame_receiver.sv
// Receive side of the three-wire DAC link: oversamples sclk/sync/mosi in the clk
// domain and rebuilds each frame into a word with decoded AD5621-style fields.
module dac_frame_receiver #(
  parameter int WORD_BITS   = 16,
  parameter bit SAMPLE_FALL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sclk,
  input  logic                 sync,
  input  logic                 mosi,
  output logic [WORD_BITS-1:0] word,
  output logic                 word_valid,
  output logic [1:0]           pd_mode,
  output logic [11:0]          dac_code,
  output logic                 frame_err,
  output logic                 busy,
  output logic [15:0]          word_count
);

  localparam int CW = $clog2(WORD_BITS + 1);

  typedef enum logic [1:0] {WAIT_HIGH, IDLE, SHIFT, DONE} state_t;

  // [0],[1] synchronizer, [2] history; left free-running so reset never fakes an edge
  logic [2:0] sclk_p, sync_p, mosi_p;

  always_ff @(posedge clk) begin
    sclk_p <= {sclk_p[1:0], sclk};
    sync_p <= {sync_p[1:0], sync};
    mosi_p <= {mosi_p[1:0], mosi};
  end

  logic samp, sync_fall, sync_rise;

  always_comb begin
    samp      = SAMPLE_FALL ? (sclk_p[2] & ~sclk_p[1]) : (~sclk_p[2] & sclk_p[1]);
    sync_fall = sync_p[2] & ~sync_p[1];
    sync_rise = ~sync_p[2] & sync_p[1];
  end

  state_t                 state;
  logic [WORD_BITS-1:0]   sh;
  logic [CW-1:0]          cnt;
  logic                   ovr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT_HIGH;
      sh         <= '0;
      cnt        <= '0;
      ovr        <= 1'b0;
      word       <= '0;
      pd_mode    <= '0;
      dac_code   <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
      word_count <= '0;
    end else begin
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        WAIT_HIGH: if (sync_p[1]) state <= IDLE;
        IDLE: if (sync_fall) begin
          sh    <= '0;
          cnt   <= '0;
          ovr   <= 1'b0;
          busy  <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          // all edges are in, so a sync rise now still delivers the word
          if (cnt == CW'(WORD_BITS)) begin
            word       <= sh;
            pd_mode    <= sh[WORD_BITS-1 -: 2];
            dac_code   <= sh[WORD_BITS-3 -: 12];
            word_valid <= 1'b1;
            word_count <= word_count + 16'd1;
            busy       <= ~sync_rise;
            state      <= sync_rise ? IDLE : DONE;
          end else if (sync_rise) begin
            frame_err <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (samp) begin
            sh  <= {sh[WORD_BITS-2:0], mosi_p[2]};
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (sync_rise) begin
            frame_err <= ovr;
            ovr       <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (samp) begin
            ovr <= 1'b1;
          end
        end
        default: state <= WAIT_HIGH;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_frame_receiver.sv
// Randomized bench for dac_frame_receiver: stimulus tasks push the events each
// frame must produce; a per-cycle monitor checks pulses, latency and held outputs.
module tb_dac_frame_receiver;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst, sclk, sync, mosi;
  logic [W-1:0]  word;
  logic          word_valid, frame_err, busy;
  logic [1:0]    pd_mode;
  logic [11:0]   dac_code;
  logic [15:0]   word_count;

  dac_frame_receiver #(.WORD_BITS(W), .SAMPLE_FALL(1'b1)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .sync(sync), .mosi(mosi),
    .word(word), .word_valid(word_valid), .pd_mode(pd_mode), .dac_code(dac_code),
    .frame_err(frame_err), .busy(busy), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           err;
    logic [W-1:0] w;
    int           cyc;
  } ev_t;

  ev_t          exp_q[$];
  int           cyc = 0;
  int           vectors = 0;
  int           miscompares = 0;
  bit           mon_on = 1'b0;
  logic [W-1:0] model_word = '0;
  int           n_good = 0;
  int           base_good = 0;
  logic [15:0]  count_base = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Frame on the link. Model rules: the W-th sample edge before sync rises
  // yields a word; a rise after fewer than W edges, or after more, yields an error.
  task automatic frame(input logic [W-1:0] data, input int nedges, input int half,
                       input int gap, input bit prio);
    ev_t e;
    sync = 1'b0;
    for (int i = 0; i < nedges; i++) begin
      mosi = (i < W) ? data[W-1-i] : 1'($urandom);
      sclk = 1'b1;
      tick(half);
      sclk = 1'b0;
      if (prio && i == nedges - 1) begin
        sync = 1'b1;
        e.err = 1'b1; e.w = '0; e.cyc = cyc;
        exp_q.push_back(e);
      end else if (i == W - 1) begin
        e.err = 1'b0; e.w = data; e.cyc = cyc;
        exp_q.push_back(e);
      end
      tick(half);
    end
    if (!prio) begin
      sync = 1'b1;
      if (nedges != W) begin
        e.err = 1'b1; e.w = '0; e.cyc = cyc;
        exp_q.push_back(e);
      end
    end
    tick(gap);
  endtask

  task automatic bare_edges(input int n, input int half);
    for (int i = 0; i < n; i++) begin
      mosi = 1'($urandom);
      sclk = 1'b1;
      tick(half);
      sclk = 1'b0;
      tick(half);
    end
  endtask

  // Per-cycle compare against the model
  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      #2;
      if (mon_on) begin
        if (rst) begin
          model_word = '0;
          exp_q.delete();
        end
        chk("valid_err_overlap", 32'(word_valid & frame_err), 32'd0);
        if (word_valid) begin
          if (exp_q.size() == 0 || exp_q[0].err) chk("unexpected_word_valid", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("word_valid_latency", 32'(cyc - e.cyc), 32'd4);
            chk("word_at_valid", 32'(word), 32'(e.w));
            model_word = e.w;
            n_good++;
          end
        end
        if (frame_err) begin
          if (exp_q.size() == 0 || !exp_q[0].err) chk("unexpected_frame_err", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("frame_err_latency", 32'(cyc - e.cyc), 32'd3);
          end
        end
        chk("word", 32'(word), 32'(model_word));
        chk("pd_mode", 32'(pd_mode), 32'(model_word[W-1:W-2]));
        chk("dac_code", 32'(dac_code), 32'(model_word[W-3:W-14]));
        chk("word_count", 32'(word_count), 32'(16'(count_base + 16'(n_good - base_good))));
      end
    end
  end

  initial begin
    int ne, hf, gp;
    bit pr;
    sclk = 1'b0; sync = 1'b1; mosi = 1'b0; rst = 1'b1;
    mon_on = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(4);
    chk("reset_word", 32'(word), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_count", 32'(word_count), 32'd0);

    // good frame
    frame(16'h2ABC, W, 4, 6, 1'b0);
    chk("good_word", 32'(word), 32'h2ABC);
    chk("good_pd", 32'(pd_mode), 32'd0);
    chk("good_code", 32'(dac_code), 32'hAAF);
    chk("good_count", 32'(word_count), 32'd1);
    chk("good_busy_after", 32'(busy), 32'd0);

    // short frame
    frame(16'($urandom), 9, 3, 5, 1'b0);
    chk("short_word_held", 32'(word), 32'h2ABC);
    chk("short_count", 32'(word_count), 32'd1);

    // overrun frame
    frame(16'hC001, 18, 3, 5, 1'b0);
    chk("ovr_word", 32'(word), 32'hC001);
    chk("ovr_pd", 32'(pd_mode), 32'd3);
    chk("ovr_code", 32'(dac_code), 32'h000);
    chk("ovr_count", 32'(word_count), 32'd2);
    chk("ovr_drained", 32'(exp_q.size()), 32'd0);

    // reset mid-frame
    sync = 1'b0;
    bare_edges(8, 3);
    chk("busy_mid_frame", 32'(busy), 32'd1);
    rst = 1'b1; count_base = '0; base_good = n_good;
    tick(2);
    rst = 1'b0;
    bare_edges(8, 3);
    sync = 1'b1;
    tick(6);
    chk("rstmid_word", 32'(word), 32'd0);
    chk("rstmid_count", 32'(word_count), 32'd0);
    frame(16'h1234, W, 3, 5, 1'b0);
    chk("after_rst_word", 32'(word), 32'h1234);
    chk("after_rst_count", 32'(word_count), 32'd1);

    // back-to-back at clk/6 with a 3-cycle gap, then priority
    for (int i = 0; i < 3; i++) frame(16'($urandom), W, 3, 3, 1'b0);
    frame(16'($urandom), W, 3, 6, 1'b1);
    chk("prio_count", 32'(word_count), 32'd4);
    chk("prio_drained", 32'(exp_q.size()), 32'd0);

    // randomized frames
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    ne = $urandom_range(5, W - 1);
        2:       ne = $urandom_range(W + 1, W + 4);
        default: ne = W;
      endcase
      hf = $urandom_range(3, 5);
      gp = $urandom_range(3, 6);
      pr = ($urandom_range(0, 9) == 0) && ne >= W;
      frame(16'($urandom), pr ? W : ne, hf, gp, pr);
    end
    tick(8);
    chk("random_drained", 32'(exp_q.size()), 32'd0);

    // counter wrap
    force dut.word_count = 16'hFFFF;
    count_base = 16'hFFFF; base_good = n_good;
    tick(1);
    release dut.word_count;
    tick(1);
    frame(16'h3FFF, W, 3, 6, 1'b0);
    chk("wrap_count", 32'(word_count), 32'd0);
    chk("wrap_word", 32'(word), 32'h3FFF);
    chk("wrap_code", 32'(dac_code), 32'hFFF);
    tick(8);
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
